// File: rtl/fifo_lvl.sv
// fifo_lvl: show-ahead synchronous FIFO with level count,
// almost-full/empty thresholds, sticky error flags and flush.
module fifo_lvl #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              wr,
  input  logic [DWIDTH-1:0] w_data,
  input  logic              rd,
  output logic [DWIDTH-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [AWIDTH:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_L = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0] AE_L = (AWIDTH+1)'(AE_LEVEL);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AWIDTH-1:0] wptr_q, wptr_d;
  logic [AWIDTH-1:0] rptr_q, rptr_d;
  logic [AWIDTH:0]   level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ae_q, ae_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_ok, rd_ok;

  // Acceptance uses registered flags so a same-cycle pop never frees room
  assign wr_ok = wr & ~full_q;
  assign rd_ok = rd & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      unique case (1'b1)
        (wr_ok & ~rd_ok): level_d = level_q + 1'b1;
        (rd_ok & ~wr_ok): level_d = level_q - 1'b1;
        default:          level_d = level_q;
      endcase
      ovf_d = ovf_q | (wr & full_q);
      udf_d = udf_q | (rd & empty_q);
    end
    empty_d = (level_d == '0);
    full_d  = (level_d == DEPTH_L);
    ae_d    = (level_d <= AE_L);
    af_d    = (level_d >= AF_L);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && wr_ok) mem_q[wptr_q] <= w_data;
  end

  assign r_data       = mem_q[rptr_q];
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: directed bench for fifo_lvl
// (DWIDTH=8, AWIDTH=4, AF=12, AE=4).
module tb_fifo_lvl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       clr;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  int n_cmp = 0;
  int n_err = 0;

  fifo_lvl #(
    .DWIDTH(8), .AWIDTH(4), .AF_LEVEL(12), .AE_LEVEL(4)
  ) dut (
    .clk(clk), .resetn(resetn), .clr(clr),
    .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_ae"}, 32'(almost_empty), 1);
    chk({tag, "_af"}, 32'(almost_full), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_udf"}, 32'(underflow), 0);
  endtask

  initial begin
    resetn = 1'b0;
    clr = 1'b0; wr = 1'b0; rd = 1'b0; w_data = '0;
    #12;
    chk_rst_vals("rst");
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_level", 32'(level), 0);
    end
    chk("idle_empty", 32'(empty), 1);

    // fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; w_data = 8'(i);
      tick();
      chk("fill_level", 32'(level), 32'(i));
      chk("fill_ae", 32'(almost_empty), (i <= 4) ? 1 : 0);
      chk("fill_af", 32'(almost_full), (i >= 12) ? 1 : 0);
      chk("fill_full", 32'(full), (i == 16) ? 1 : 0);
      chk("fill_empty", 32'(empty), 0);
      chk("fill_head", 32'(r_data), 32'h01);
    end
    w_data = 8'hAA;
    tick();
    wr = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 16);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_head", 32'(r_data), 32'h01);
    chk("ovf_udf", 32'(underflow), 0);

    // drain
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", 32'(r_data), 32'(i));
      rd = 1'b1;
      tick();
      chk("drain_level", 32'(level), 32'(16 - i));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_ae", 32'(almost_empty), 1);
    tick();
    rd = 1'b0;
    chk("udf_set", 32'(underflow), 1);
    chk("udf_level", 32'(level), 0);
    chk("udf_ovf_hold", 32'(overflow), 1);

    // wrap-around with simultaneous traffic
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_udf", 32'(underflow), 0);
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; w_data = 8'(i);
      tick();
    end
    chk("pre_level", 32'(level), 3);
    rd = 1'b1;
    for (int c = 0; c < 40; c++) begin
      w_data = 8'(c + 3);
      chk("wrap_data", 32'(r_data), 32'(c));
      tick();
      chk("wrap_level", 32'(level), 3);
    end
    wr = 1'b0; rd = 1'b0;
    chk("wrap_head", 32'(r_data), 32'd40);
    chk("wrap_ovf", 32'(overflow), 0);
    chk("wrap_udf", 32'(underflow), 0);

    // empty with wr=rd=1
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wr = 1'b1; rd = 1'b1; w_data = 8'h55;
    tick();
    wr = 1'b0; rd = 1'b0;
    chk("e_wr_rd_level", 32'(level), 1);
    chk("e_wr_rd_udf", 32'(underflow), 1);
    chk("e_wr_rd_empty", 32'(empty), 0);
    chk("e_wr_rd_data", 32'(r_data), 32'h55);

    // full with wr=rd=1
    for (int i = 0; i < 15; i++) begin
      wr = 1'b1; w_data = 8'(8'h60 + i);
      tick();
    end
    chk("f_pre_full", 32'(full), 1);
    chk("f_pre_ovf", 32'(overflow), 0);
    rd = 1'b1; w_data = 8'hBB;
    tick();
    wr = 1'b0; rd = 1'b0;
    chk("f_wr_rd_level", 32'(level), 15);
    chk("f_wr_rd_ovf", 32'(overflow), 1);
    chk("f_wr_rd_full", 32'(full), 0);
    chk("f_wr_rd_head", 32'(r_data), 32'h60);

    // flush at level 9 with both errors set
    clr = 1'b1;
    tick();
    clr = 1'b0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr = 1'b1; w_data = 8'(8'h80 + i);
      tick();
    end
    wr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
    chk("l9_level", 32'(level), 9);
    chk("l9_ovf", 32'(overflow), 1);
    chk("l9_udf", 32'(underflow), 1);
    chk("l9_af", 32'(almost_full), 0);
    chk("l9_ae", 32'(almost_empty), 0);
    chk("l9_head", 32'(r_data), 32'h87);
    clr = 1'b1; wr = 1'b1; w_data = 8'hEE;
    tick();
    clr = 1'b0; wr = 1'b0;
    chk_rst_vals("flush");
    wr = 1'b1; w_data = 8'h77;
    tick();
    wr = 1'b0;
    chk("post_flush_level", 32'(level), 1);
    chk("post_flush_data", 32'(r_data), 32'h77);

    // async reset mid-burst
    rd = 1'b1;
    tick();
    rd = 1'b0;
    wr = 1'b1; w_data = 8'h31;
    tick();
    tick();
    tick();
    chk("burst_level", 32'(level), 3);
    #2;
    resetn = 1'b0;
    #1;
    chk_rst_vals("async_rst");
    wr = 1'b0;
    #2;
    resetn = 1'b1;
    tick();
    chk("rst_idle_level", 32'(level), 0);
    wr = 1'b1; w_data = 8'h42;
    tick();
    wr = 1'b0;
    chk("rst_wr_level", 32'(level), 1);
    chk("rst_wr_data", 32'(r_data), 32'h42);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
